// File: rtl/lock_pkg.sv
// lock_pkg: shared types and default constants for the combination lock.
// Holds the FSM state encoding and the default parameter values used by
// lock_ctrl and code_det, plus a small helper for sizing the cycle counter.
package lock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    CHECK,
    OPEN,
    ERR,
    LOCKOUT
  } lock_state_t;

  localparam int         DEF_CODE_LEN    = 5;
  localparam logic [4:0] DEF_CODE        = 5'b11001;
  localparam int         DEF_OPEN_CYC    = 16;
  localparam int         DEF_LOCK_CYC    = 64;
  localparam int         DEF_MAX_FAIL    = 3;
  localparam int         DEF_TIMEOUT_CYC = 32;

  // Largest of three durations; sizes the shared cycle counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lock_ctrl_code_det.sv
// code_det: collects key bits and compares them with the secret code.
// Ports:
//   clk, reset  - clock, asynchronous active-low reset
//   en          - accept code_bit this cycle (shift + count)
//   code_bit    - one key bit; the first bit entered ends up in the MSB
//   clr         - discard the partial/complete entry
//   done        - the bit being accepted now completes the code
//   match       - registered: collected code equals CODE (valid one cycle
//                 after the last bit was shifted in)
module code_det
  import lock_pkg::*;
#(
  parameter int                  CODE_LEN = DEF_CODE_LEN,
  parameter logic [CODE_LEN-1:0] CODE     = DEF_CODE
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic code_bit,
  input  logic clr,
  output logic done,
  output logic match
);

  localparam int CNT_W = $clog2(CODE_LEN + 1);

  logic [CODE_LEN-1:0] code_reg;
  logic [CNT_W-1:0]    bit_cnt;

  // done looks at the accepting edge itself so the FSM can leave ENTRY on
  // the same edge that captures the final bit.
  assign done = en && (bit_cnt == CNT_W'(CODE_LEN - 1));

  // Shift register and bit counter. The comparator output is registered,
  // which is why the FSM spends two cycles in CHECK before acting on it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_reg <= '0;
      bit_cnt  <= '0;
      match    <= 1'b0;
    end else begin
      match <= (code_reg == CODE);
      if (clr) begin
        code_reg <= '0;
        bit_cnt  <= '0;
      end else if (en) begin
        code_reg <= {code_reg[CODE_LEN-2:0], code_bit};
        bit_cnt  <= bit_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/lock_ctrl.sv
// lock_ctrl: serial-key combination lock with failure lockout.
// Ports:
//   clk, reset - clock, asynchronous active-low reset
//   key_valid  - key_bit is presented this cycle
//   key_bit    - one code bit
//   unlock     - door released (OPEN_CYC cycles)
//   alarm      - lockout active (LOCK_CYC cycles)
//   err        - one-cycle pulse after a wrong code
//   busy       - keys are ignored this cycle
//   fail_cnt   - consecutive wrong attempts, saturating at MAX_FAIL
module lock_ctrl
  import lock_pkg::*;
#(
  parameter int                  CODE_LEN    = DEF_CODE_LEN,
  parameter logic [CODE_LEN-1:0] CODE        = DEF_CODE,
  parameter int                  OPEN_CYC    = DEF_OPEN_CYC,
  parameter int                  LOCK_CYC    = DEF_LOCK_CYC,
  parameter int                  MAX_FAIL    = DEF_MAX_FAIL,
  parameter int                  TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic       key_bit,
  output logic       unlock,
  output logic       alarm,
  output logic       err,
  output logic       busy,
  output logic [1:0] fail_cnt
);

  localparam int CNT_W = $clog2(max3(OPEN_CYC, LOCK_CYC, TIMEOUT_CYC) + 1);

  lock_state_t      state;
  logic [CNT_W-1:0] cyc;
  logic             det_en;
  logic             det_clr;
  logic             det_done;
  logic             det_match;
  logic             abort;
  logic [1:0]       fail_next;

  // Keys only reach the detector while an attempt can be collected.
  assign det_en = key_valid && ((state == IDLE) || (state == ENTRY));

  assign abort = (state == ENTRY) && !key_valid &&
                 (cyc == CNT_W'(TIMEOUT_CYC - 1));

  // Second CHECK cycle: the verdict is taken now, so the entry can go.
  assign det_clr = abort || ((state == CHECK) && (cyc != '0));

  assign fail_next = (fail_cnt >= 2'(MAX_FAIL)) ? 2'(MAX_FAIL)
                                                : fail_cnt + 2'd1;

  code_det #(
    .CODE_LEN (CODE_LEN),
    .CODE     (CODE)
  ) u_code_det (
    .clk      (clk),
    .reset    (reset),
    .en       (det_en),
    .code_bit (key_bit),
    .clr      (det_clr),
    .done     (det_done),
    .match    (det_match)
  );

  // Main FSM. Outputs are assigned on the same edge as the state they
  // belong to, so they are registered and track the state exactly. The
  // shared cycle counter restarts on every state change (and, in ENTRY,
  // on every accepted key, since the timeout measures idle gaps).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cyc      <= '0;
      unlock   <= 1'b0;
      alarm    <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      fail_cnt <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          cyc <= '0;
          if (key_valid) begin
            state <= ENTRY;
          end
        end

        ENTRY: begin
          if (key_valid) begin
            cyc <= '0;
            if (det_done) begin
              state <= CHECK;
              busy  <= 1'b1;
            end
          end else if (abort) begin
            state <= IDLE;
            cyc   <= '0;
          end else begin
            cyc <= cyc + CNT_W'(1);
          end
        end

        CHECK: begin
          if (cyc == '0) begin
            cyc <= CNT_W'(1);
          end else begin
            cyc <= '0;
            if (det_match) begin
              state    <= OPEN;
              unlock   <= 1'b1;
              fail_cnt <= 2'd0;
            end else if (fail_next == 2'(MAX_FAIL)) begin
              state    <= LOCKOUT;
              alarm    <= 1'b1;
              fail_cnt <= fail_next;
            end else begin
              state    <= ERR;
              err      <= 1'b1;
              fail_cnt <= fail_next;
            end
          end
        end

        OPEN: begin
          if (cyc == CNT_W'(OPEN_CYC - 1)) begin
            state  <= IDLE;
            cyc    <= '0;
            unlock <= 1'b0;
            busy   <= 1'b0;
          end else begin
            cyc <= cyc + CNT_W'(1);
          end
        end

        ERR: begin
          state <= IDLE;
          cyc   <= '0;
          err   <= 1'b0;
          busy  <= 1'b0;
        end

        LOCKOUT: begin
          if (cyc == CNT_W'(LOCK_CYC - 1)) begin
            state    <= IDLE;
            cyc      <= '0;
            alarm    <= 1'b0;
            busy     <= 1'b0;
            fail_cnt <= 2'd0;
          end else begin
            cyc <= cyc + CNT_W'(1);
          end
        end

        default: begin
          state  <= IDLE;
          cyc    <= '0;
          unlock <= 1'b0;
          alarm  <= 1'b0;
          err    <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lock_ctrl.sv
// tb_lock_ctrl: directed scoreboard bench for lock_ctrl.
// Stimulus pushes the expected output event (kind, start cycle, length,
// fail_cnt) when an attempt is keyed in; a monitor detects rising edges of
// unlock/err/alarm, pops the queue and compares.
module tb_lock_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_valid = 1'b0;
  logic       key_bit = 1'b0;
  logic       unlock;
  logic       alarm;
  logic       err;
  logic       busy;
  logic [1:0] fail_cnt;

  localparam int EV_UNLOCK = 0;
  localparam int EV_ERR    = 1;
  localparam int EV_ALARM  = 2;

  typedef struct {
    int kind;
    int start;
    int dur;
    int fcnt;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cycle = 0;

  lock_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_bit   (key_bit),
    .unlock    (unlock),
    .alarm     (alarm),
    .err       (err),
    .busy      (busy),
    .fail_cnt  (fail_cnt)
  );

  always #5 clk = ~clk;

  // Rising-edge counter; read #1 after an edge it equals that edge's index.
  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Value is sampled by the DUT at the following rising edge.
  task automatic drive_bit(input logic b);
    @(posedge clk);
    #1;
    key_valid = 1'b1;
    key_bit   = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      key_valid = 1'b0;
    end
  endtask

  task automatic drive_code(input logic [4:0] code);
    for (int i = 4; i >= 0; i--) drive_bit(code[i]);
  endtask

  // Last bit is driven at edge N, sampled at N+1, CHECK covers N+1..N+2,
  // so the response starts at edge N+3.
  task automatic applyStimulus(input logic [4:0] code, input int kind,
                               input int dur, input int fcnt);
    exp_t e;
    drive_code(code);
    e.kind  = kind;
    e.start = cycle + 3;
    e.dur   = dur;
    e.fcnt  = fcnt;
    sb.push_back(e);
  endtask

  function automatic logic sig_of(input int k);
    if (k == EV_UNLOCK) return unlock;
    if (k == EV_ERR) return err;
    return alarm;
  endfunction

  // Monitor: sample on the falling edge, away from the active edge.
  initial begin : monitor
    logic pu, pe, pa;
    int   k;
    int   d;
    exp_t e;
    pu = 1'b0;
    pe = 1'b0;
    pa = 1'b0;
    forever begin
      @(negedge clk);
      if ((unlock && !pu) || (err && !pe) || (alarm && !pa)) begin
        k = unlock ? EV_UNLOCK : (err ? EV_ERR : EV_ALARM);
        if (sb.size() == 0) begin
          checkOutput("unexpected_event", k, -1);
        end else begin
          e = sb.pop_front();
          checkOutput("event_kind", k, e.kind);
          checkOutput("event_start", cycle, e.start);
          checkOutput("event_fail_cnt", int'(fail_cnt), e.fcnt);
          d = 1;
          for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sig_of(k)) d++;
            else break;
          end
          checkOutput("event_len", d, e.dur);
        end
      end
      pu = unlock;
      pe = err;
      pa = alarm;
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    exp_t e;
    int   t0;

    // Reset values while reset is held low.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_unlock", int'(unlock), 0);
    checkOutput("rst_alarm", int'(alarm), 0);
    checkOutput("rst_err", int'(err), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_fail_cnt", int'(fail_cnt), 0);
    reset = 1'b1;
    idle(2);

    // Correct code opens for 16 cycles.
    applyStimulus(5'b11001, EV_UNLOCK, 16, 0);
    idle(22);

    // Wrong code: one-cycle err, fail_cnt 1, back to idle.
    applyStimulus(5'b10001, EV_ERR, 1, 1);
    idle(4);
    checkOutput("fail_cnt_after_err", int'(fail_cnt), 1);
    checkOutput("busy_after_err", int'(busy), 0);

    // Second and third wrong codes: err, then 64-cycle lockout.
    applyStimulus(5'b00000, EV_ERR, 1, 2);
    idle(4);
    applyStimulus(5'b01010, EV_ALARM, 64, 3);
    idle(4);
    checkOutput("busy_in_lockout", int'(busy), 1);
    checkOutput("alarm_in_lockout", int'(alarm), 1);
    // The correct code keyed during lockout must be dropped.
    drive_code(5'b11001);
    idle(70);
    checkOutput("fail_cnt_after_lockout", int'(fail_cnt), 0);
    checkOutput("alarm_after_lockout", int'(alarm), 0);
    checkOutput("busy_after_lockout", int'(busy), 0);

    // Wrong then correct, with a wrong code keyed during OPEN.
    applyStimulus(5'b10001, EV_ERR, 1, 1);
    idle(4);
    applyStimulus(5'b11001, EV_UNLOCK, 16, 0);
    idle(4);
    drive_code(5'b10001);
    idle(20);
    checkOutput("fail_cnt_after_open", int'(fail_cnt), 0);

    // Timeout: 1,1 then 32 idle cycles aborts silently, fail_cnt kept.
    applyStimulus(5'b10001, EV_ERR, 1, 1);
    idle(4);
    drive_bit(1'b1);
    drive_bit(1'b1);
    idle(32);
    checkOutput("fail_cnt_after_abort", int'(fail_cnt), 1);
    checkOutput("busy_after_abort", int'(busy), 0);
    applyStimulus(5'b11001, EV_UNLOCK, 16, 0);
    idle(22);

    // 31 idle cycles is still inside the attempt: 11 + 001 completes it.
    drive_bit(1'b1);
    drive_bit(1'b1);
    idle(31);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    e.kind  = EV_UNLOCK;
    e.start = cycle + 3;
    e.dur   = 16;
    e.fcnt  = 0;
    sb.push_back(e);
    idle(22);

    // Reset pulsed during lockout cycle 10.
    applyStimulus(5'b10001, EV_ERR, 1, 1);
    idle(4);
    applyStimulus(5'b10001, EV_ERR, 1, 2);
    idle(4);
    applyStimulus(5'b10001, EV_ALARM, 10, 3);
    t0 = cycle;
    while (cycle < t0 + 13) begin
      @(posedge clk);
      #1;
      key_valid = 1'b0;
    end
    reset = 1'b0;
    #1;
    checkOutput("lockrst_alarm", int'(alarm), 0);
    checkOutput("lockrst_unlock", int'(unlock), 0);
    checkOutput("lockrst_err", int'(err), 0);
    checkOutput("lockrst_busy", int'(busy), 0);
    checkOutput("lockrst_fail_cnt", int'(fail_cnt), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(2);
    applyStimulus(5'b11001, EV_UNLOCK, 16, 0);
    idle(22);

    idle(5);
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
